// File: rtl/mult_rr_arbiter.sv
// Round-robin arbiter sharing one unsigned WIDTH x WIDTH multiplier among N requesters.
// The product is held in a valid/ready output register tagged with the requester index.
module mult_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int IDW   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  input  logic [N*WIDTH-1:0]   req_a,
  input  logic [N*WIDTH-1:0]   req_b,
  output logic [N-1:0]         req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic [IDW-1:0]       out_id
);

  logic [IDW-1:0]     ptr_r;
  logic [IDW-1:0]     gnt_s;
  logic               any_s;
  logic               free_s;
  logic               accept_s;
  logic [WIDTH-1:0]   a_s;
  logic [WIDTH-1:0]   b_s;
  logic [2*WIDTH-1:0] product_s;
  logic [IDW-1:0]     ptr_next_s;
  logic               out_valid_r;
  logic [2*WIDTH-1:0] out_product_r;
  logic [IDW-1:0]     out_id_r;

  // Rotating priority search starting at ptr_r; first valid requester wins.
  always_comb begin : grant_sel
    int idx;
    gnt_s = '0;
    any_s = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_r) + k;
      if (idx >= N) idx = idx - N;
      else          idx = idx;
      if (!any_s && req_valid[idx]) begin
        any_s = 1'b1;
        gnt_s = IDW'(idx);
      end else begin
        gnt_s = gnt_s;
      end
    end
  end

  // Handshake terms, operand mux, full-width multiply and next pointer.
  always_comb begin
    free_s    = !out_valid_r || out_ready;
    accept_s  = free_s && any_s;
    a_s       = req_a[gnt_s*WIDTH +: WIDTH];
    b_s       = req_b[gnt_s*WIDTH +: WIDTH];
    product_s = {{WIDTH{1'b0}}, a_s} * {{WIDTH{1'b0}}, b_s};
    if (gnt_s == IDW'(N-1)) ptr_next_s = '0;
    else                    ptr_next_s = gnt_s + IDW'(1);
  end

  // One-hot ready for the granted requester; forced low while in reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && accept_s) req_ready[gnt_s] = 1'b1;
    else                   req_ready = '0;
  end

  // Output register and priority pointer; accept overrides a simultaneous drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r   <= 1'b0;
      out_product_r <= '0;
      out_id_r      <= '0;
      ptr_r         <= '0;
    end else if (accept_s) begin
      out_valid_r   <= 1'b1;
      out_product_r <= product_s;
      out_id_r      <= gnt_s;
      ptr_r         <= ptr_next_s;
    end else if (out_valid_r && out_ready) begin
      out_valid_r   <= 1'b0;
    end else begin
      out_valid_r   <= out_valid_r;
    end
  end

  assign out_valid   = out_valid_r;
  assign out_product = out_product_r;
  assign out_id      = out_id_r;

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Directed self-checking bench for mult_rr_arbiter (WIDTH=8, N=4).
module tb_mult_rr_arbiter;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int IDW   = 2;

  logic                 clk;
  logic                 rst_n;
  logic [N-1:0]         req_valid;
  logic [N*WIDTH-1:0]   req_a;
  logic [N*WIDTH-1:0]   req_b;
  logic [N-1:0]         req_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_product;
  logic [IDW-1:0]       out_id;

  int tests;
  int fails;

  mult_rr_arbiter #(.WIDTH(WIDTH), .N(N), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_id(out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  initial begin : stim
    int rr_id [5];
    int rr_prod [5];
    rr_id   = '{0, 1, 2, 3, 0};
    rr_prod = '{6, 20, 42, 72, 6};
    tests = 0;
    fails = 0;
    rst_n = 1'b0; req_valid = 4'b1111; req_a = '0; req_b = '0; out_ready = 1'b0;
    tick(); tick();
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_product", 32'(out_product), 32'd0);
    check("reset_id", 32'(out_id), 32'd0);
    check("reset_ready_gated", 32'(req_ready), 32'd0);

    // Accept requester 0, then stall with a product held.
    rst_n = 1'b1; req_valid = 4'b0001; set_ops(0, 8'd5, 8'd6); #1;
    check("first_ready", 32'(req_ready), 32'b0001);
    tick();
    check("first_product", 32'(out_product), 32'd30);
    req_valid = 4'b0101; #1;
    check("stall_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b0; tick();
    check("midstall_rst_valid", 32'(out_valid), 32'd0);
    check("midstall_rst_product", 32'(out_product), 32'd0);
    check("midstall_rst_id", 32'(out_id), 32'd0);
    check("midstall_rst_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1; out_ready = 1'b1; #1;
    check("post_rst_prio0", 32'(req_ready), 32'b0001);
    tick();
    check("post_rst_id", 32'(out_id), 32'd0);

    // Single requester at maximum operands.
    req_valid = 4'b0010; set_ops(1, 8'd255, 8'd255); #1;
    check("single_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b0000; #1;
    check("single_product", 32'(out_product), 32'd65025);
    check("single_id", 32'(out_id), 32'd1);
    check("single_ready_after", 32'(req_ready), 32'd0);
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_stale_product", 32'(out_product), 32'd65025);

    // Wrap-around: grant 2, then 3 and 0, then 3 alone.
    req_valid = 4'b0100; tick();
    check("wrap_id2", 32'(out_id), 32'd2);
    req_valid = 4'b1001; #1;
    check("wrap_ready3", 32'(req_ready), 32'b1000);
    tick();
    check("wrap_id3", 32'(out_id), 32'd3);
    check("wrap_ready0", 32'(req_ready), 32'b0001);
    tick();
    check("wrap_id0", 32'(out_id), 32'd0);
    req_valid = 4'b1000; #1;
    check("wrap_ready3_again", 32'(req_ready), 32'b1000);
    tick();
    check("wrap_id3_again", 32'(out_id), 32'd3);

    // Round-robin with all four requesters, pointer back at 0.
    set_ops(0, 8'd2, 8'd3); set_ops(1, 8'd4, 8'd5);
    set_ops(2, 8'd6, 8'd7); set_ops(3, 8'd8, 8'd9);
    req_valid = 4'b1111; #1;
    for (int i = 0; i < 5; i++) begin
      check("rr_ready", 32'(req_ready), 32'd1 << rr_id[i]);
      tick();
      check("rr_id", 32'(out_id), 32'(rr_id[i]));
      check("rr_product", 32'(out_product), 32'(rr_prod[i]));
      check("rr_valid", 32'(out_valid), 32'd1);
    end

    // Backpressure: hold requester 3's product while requester 0 waits.
    req_valid = 4'b1000; set_ops(3, 8'd10, 8'd12); tick();
    check("bp_product3", 32'(out_product), 32'd120);
    out_ready = 1'b0; req_valid = 4'b0001; set_ops(0, 8'd11, 8'd13);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_product_hold", 32'(out_product), 32'd120);
      check("bp_id_hold", 32'(out_id), 32'd3);
      check("bp_valid_hold", 32'(out_valid), 32'd1);
      tick();
    end
    out_ready = 1'b1; #1;
    check("bp_release_ready", 32'(req_ready), 32'b0001);
    tick();
    check("bp_release_product", 32'(out_product), 32'd143);
    check("bp_release_id", 32'(out_id), 32'd0);

    // Drain and idle: one accept of requester 2 (ptr -> 3), then nothing.
    req_valid = 4'b0100; tick();
    req_valid = 4'b0000; #1;
    check("idle_valid_one", 32'(out_valid), 32'd1);
    tick();
    check("idle_valid_zero", 32'(out_valid), 32'd0);
    tick();
    check("idle_valid_still_zero", 32'(out_valid), 32'd0);
    req_valid = 4'b1111; #1;
    check("idle_ptr_held", 32'(req_ready), 32'b1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
